div_ratio_sched: RTL

//  Run-time scheduler for a programmable 50%-duty clock divider (odd and even ratios).

---
 rtl/div_pkg.sv | 15 +
 rtl/div_prog_core.sv | 66 ++++++
 rtl/div_ratio_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the programmable clock-divider scheduler.
package div_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } sched_state_t;

    localparam int unsigned MIN_DIV = 2;

    function automatic logic div_legal(input int unsigned div, input int unsigned max_div);
        return (div >= MIN_DIV) && (div <= max_div);
    endfunction

endpackage

// File: rtl/div_prog_core.sv
// 50%-duty programmable divider datapath: period counter, rising/falling phase
// registers and odd/even output select, all retimed only at period boundaries.
module div_prog_core
    import div_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 15
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    input  logic [CNT_W-1:0] cur_div,
    output logic             boundary,
    output logic             clk_out
);

    localparam logic DEF_ODD = 1'(DEF_DIV % 2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W:0]   half_nxt;
    logic             clk_r;
    logic             clk_f;
    logic             odd;

    assign boundary = (cnt == cur_div - CNT_W'(1));

    // A load with en low keeps the counter parked at the new ratio's last count.
    always_comb begin
        div_nxt  = load ? load_div : cur_div;
        half_nxt = ({1'b0, div_nxt} + (CNT_W+1)'(1)) >> 1;
        cnt_nxt  = cnt + CNT_W'(1);
        if (boundary || load) begin
            cnt_nxt = en ? '0 : div_nxt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            clk_r <= 1'b0;
            odd   <= DEF_ODD;
        end else begin
            cnt   <= cnt_nxt;
            clk_r <= ({1'b0, cnt_nxt} < half_nxt);
            if (boundary || load) begin
                odd <= div_nxt[0];
            end
        end
    end

    always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) begin
            clk_f <= 1'b0;
        end else begin
            clk_f <= clk_r;
        end
    end

    // Both phases are low at a boundary, so changing odd there cannot glitch.
    assign clk_out = clk_r & (clk_f | ~odd);

endmodule

// File: rtl/div_ratio_sched.sv
// Ratio request handshake, legality check and boundary-aligned ratio update
// for the programmable clock divider; also tracks output lock status.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request; illegal ratios are rejected here
// ST_PEND | legal ratio held in pend_div, waiting for the next boundary
module div_ratio_sched
    import div_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 15,
    parameter int unsigned MAX_DIV = 255
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_div,
    output logic             req_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_div,
    output logic             locked,
    output logic             clk_out
);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [CNT_W-1:0] pend_div;
    logic             accept;
    logic             req_legal;
    logic             load;
    logic             boundary;
    logic             parked;

    assign req_legal = div_legal(32'(req_div), MAX_DIV);
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && req_legal) begin
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (boundary) begin
                    load      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            pend_div <= '0;
            cur_div  <= CNT_W'(DEF_DIV);
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            locked   <= 1'b0;
            parked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cfg_done <= load;
            cfg_err  <= accept & ~req_legal;
            parked   <= boundary & ~en;
            if (accept && req_legal) begin
                pend_div <= req_div;
            end
            if (load) begin
                cur_div <= pend_div;
            end
            // Lock needs one full running period; a restart from park is not one.
            if (accept && req_legal) begin
                locked <= 1'b0;
            end else if (boundary && !en) begin
                locked <= 1'b0;
            end else if (boundary && !parked && !load) begin
                locked <= 1'b1;
            end
        end
    end

    div_prog_core #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_core (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_div (pend_div),
        .cur_div  (cur_div),
        .boundary (boundary),
        .clk_out  (clk_out)
    );

endmodule
